// File: rtl/omr_pkg.sv
// Shared constants and helpers for the optical-mark-reader grader.
package omr_pkg;

   localparam int NUM_Q_DEF   = 10;
   localparam int NUM_OPT_DEF = 4;
   localparam int SCORE_W_DEF = 4;

   // Widest option field the one-hot helper accepts; narrower fields are zero-extended.
   localparam int MAX_OPT = 32;

   function automatic logic is_one_hot(input logic [MAX_OPT-1:0] f);
      return (f != '0) && ((f & (f - MAX_OPT'(1))) == '0);
   endfunction

endpackage

// File: rtl/omr_grader_if.sv
// Sheet-in / score-out bus between the scan front end, the grader and the display logic.
interface omr_grader_if
   import omr_pkg::*;
#(
   parameter int NUM_Q   = NUM_Q_DEF,
   parameter int NUM_OPT = NUM_OPT_DEF,
   parameter int SCORE_W = SCORE_W_DEF
);
   // Valid-only handshake: in_valid marks a sheet for exactly one cycle, there is
   // no ready; score_valid pulses one cycle later with score/score1 updated.
   logic                     in_valid;
   logic [NUM_Q*NUM_OPT-1:0] correct_answers;
   logic [NUM_Q*NUM_OPT-1:0] student_answers;
   logic [SCORE_W-1:0]       score;
   logic [SCORE_W-1:0]       score1;
   logic                     score_valid;

   modport master (
      output in_valid, correct_answers, student_answers,
      input  score, score1, score_valid
   );

   modport slave (
      input  in_valid, correct_answers, student_answers,
      output score, score1, score_valid
   );
endinterface

// File: rtl/omr_question_grader.sv
// Classifies one question field as correct, wrong or blank against its key field.
module omr_question_grader
   import omr_pkg::*;
#(
   parameter int NUM_OPT = NUM_OPT_DEF
) (
   input  logic [NUM_OPT-1:0] key_i,
   input  logic [NUM_OPT-1:0] student_i,
   output logic               correct_o,
   output logic               wrong_o
);

   logic key_ok;
   logic attempted;

   assign key_ok    = is_one_hot(MAX_OPT'(key_i));
   assign attempted = |student_i;

   // Equality against a one-hot key implies a single mark, so multi-marks fall to wrong.
   assign correct_o = key_ok && (student_i == key_i);
   assign wrong_o   = attempted && !correct_o;

endmodule

// File: rtl/omr_grader.sv
// Grades one answer sheet per cycle: per-question classification, two popcounts,
// registered results with a one-cycle valid pulse.
module omr_grader
   import omr_pkg::*;
#(
   parameter int NUM_Q   = NUM_Q_DEF,
   parameter int NUM_OPT = NUM_OPT_DEF,
   parameter int SCORE_W = SCORE_W_DEF
) (
   input logic         clk,
   input logic         rst_n,
   omr_grader_if.slave bus
);

   logic [NUM_Q-1:0]   correct_vec;
   logic [NUM_Q-1:0]   wrong_vec;
   logic [SCORE_W-1:0] score_d,  score_q;
   logic [SCORE_W-1:0] score1_d, score1_q;
   logic               valid_q;

   for (genvar gk = 0; gk < NUM_Q; gk++) begin : g_q
      omr_question_grader #(
         .NUM_OPT (NUM_OPT)
      ) u_q (
         .key_i     (bus.correct_answers[gk*NUM_OPT +: NUM_OPT]),
         .student_i (bus.student_answers[gk*NUM_OPT +: NUM_OPT]),
         .correct_o (correct_vec[gk]),
         .wrong_o   (wrong_vec[gk])
      );
   end

   // correct and wrong are exclusive per question, so the two sums never exceed NUM_Q.
   always_comb begin
      score_d  = '0;
      score1_d = '0;
      for (int k = 0; k < NUM_Q; k++) begin
         score_d  = score_d  + SCORE_W'(correct_vec[k]);
         score1_d = score1_d + SCORE_W'(wrong_vec[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q  <= '0;
         score1_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            score_q  <= score_d;
            score1_q <= score1_d;
         end
      end
   end

   assign bus.score       = score_q;
   assign bus.score1      = score1_q;
   assign bus.score_valid = valid_q;

endmodule

// File: tb/tb_omr_grader.sv
// Randomized and directed bench for omr_grader against a per-question reference model.
module tb_omr_grader;

   localparam int NQ = 10;
   localparam int NO = 4;
   localparam int SW = 4;
   localparam int DW = NQ*NO;

   localparam logic [DW-1:0] KEY      = 40'b0001_0010_0010_0100_0001_0010_0001_1000_1000_1000;
   localparam logic [DW-1:0] ST_PART  = 40'b1000_0010_0010_0100_0010_0100_0100_0100_1000_0010;
   localparam logic [DW-1:0] ST_MULTI = 40'b1000_0100_0010_0001_0101_0010_0100_0010_0001_0010;
   localparam logic [DW-1:0] ST_WRONG = 40'b0100_0001_0100_1000_1000_0100_0100_0100_0001_0001;
   localparam logic [DW-1:0] ST_B2B   = 40'b0001_0010_0010_0100_0001_0010_0001_0010_0001_1000;

   logic clk;
   logic rst_n;

   omr_grader_if #(.NUM_Q(NQ), .NUM_OPT(NO), .SCORE_W(SW)) bus ();

   omr_grader #(.NUM_Q(NQ), .NUM_OPT(NO), .SCORE_W(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   logic [2*SW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: each question judged on its own, then counted.
   function automatic logic [2*SW-1:0] model(input logic [DW-1:0] key, input logic [DW-1:0] stu);
      int n_ok = 0;
      int n_bad = 0;
      logic [NO-1:0] kf, sf;
      for (int q = 0; q < NQ; q++) begin
         kf = key[q*NO +: NO];
         sf = stu[q*NO +: NO];
         if ($countones(kf) == 1 && sf == kf) n_ok++;
         else if (sf != 0) n_bad++;
      end
      return {SW'(n_ok), SW'(n_bad)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic [DW-1:0] key, input logic [DW-1:0] stu, input logic [2*SW-1:0] exp);
      @(negedge clk);
      bus.in_valid        = 1'b1;
      bus.correct_answers = key;
      bus.student_answers = stu;
      if (rst_n) exp_q.push_back(exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid        = 1'b0;
         bus.correct_answers = 40'(32'($urandom));
         bus.student_answers = 40'(32'($urandom));
      end
   endtask

   function automatic logic [DW-1:0] rand_key();
      logic [DW-1:0] k;
      for (int q = 0; q < NQ; q++) begin
         if ($urandom_range(0, 4) == 0) k[q*NO +: NO] = NO'($urandom_range(0, 15));
         else                           k[q*NO +: NO] = NO'(1 << $urandom_range(0, NO-1));
      end
      return k;
   endfunction

   function automatic logic [DW-1:0] rand_stu(input logic [DW-1:0] key);
      logic [DW-1:0] s;
      for (int q = 0; q < NQ; q++) begin
         case ($urandom_range(0, 3))
            0:       s[q*NO +: NO] = '0;
            1:       s[q*NO +: NO] = key[q*NO +: NO];
            2:       s[q*NO +: NO] = NO'(1 << $urandom_range(0, NO-1));
            default: s[q*NO +: NO] = NO'($urandom_range(0, 15));
         endcase
      end
      return s;
   endfunction

   // ---------------- monitor ----------------
   logic [2*SW-1:0] last_res = '0;

   always begin
      logic was_v, in_rst;
      logic [2*SW-1:0] exp;
      @(posedge clk);
      was_v  = bus.in_valid && rst_n;
      in_rst = !rst_n;
      #1;
      if (in_rst) begin
         last_res = '0;
         check("rst_valid", 32'(bus.score_valid), 32'd0);
         check("rst_scores", 32'({bus.score, bus.score1}), 32'd0);
      end else if (was_v) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         last_res = exp;
         check("valid_pulse", 32'(bus.score_valid), 32'd1);
         check("score", 32'(bus.score), 32'(exp[2*SW-1:SW]));
         check("score1", 32'(bus.score1), 32'(exp[SW-1:0]));
      end else begin
         check("valid_idle", 32'(bus.score_valid), 32'd0);
         check("hold", 32'({bus.score, bus.score1}), 32'(last_res));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] k, s;
      rst_n               = 1'b1;
      bus.in_valid        = 1'b0;
      bus.correct_answers = '0;
      bus.student_answers = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_score", 32'(bus.score), 32'd0);
      check("reset_score1", 32'(bus.score1), 32'd0);
      check("reset_valid", 32'(bus.score_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      send(KEY, KEY,      {4'd10, 4'd0}); idle(2);
      send(KEY, ST_PART,  {4'd4,  4'd6}); idle(1);
      send(KEY, ST_MULTI, {4'd2,  4'd8}); idle(3);
      send(KEY, ST_WRONG, {4'd0,  4'd10}); idle(1);
      send(KEY, '0,       {4'd0,  4'd0}); idle(2);
      send(KEY, KEY,      {4'd10, 4'd0});
      send(KEY, ST_B2B,   {4'd8,  4'd2}); idle(2);

      // Mid-cycle asynchronous reset right after a result appears.
      send(KEY, KEY, {4'd10, 4'd0});
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_score", 32'(bus.score), 32'd0);
      check("async_rst_score1", 32'(bus.score1), 32'd0);
      check("async_rst_valid", 32'(bus.score_valid), 32'd0);
      send(KEY, KEY, {4'd10, 4'd0});
      send(KEY, ST_PART, {4'd4, 4'd6});
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      idle(3);
      send(KEY, ST_MULTI, {4'd2, 4'd8}); idle(1);

      for (int n = 0; n < 300; n++) begin
         k = rand_key();
         s = rand_stu(k);
         send(k, s, model(k, s));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(3);

      check("drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/omr_grader.md
Name: omr_grader

Overview:
- Optical-mark-reader grading block.
- Compares a student answer sheet against an answer key. Each question is one-hot coded over its options.
- Produces two registered counts: correct answers and attempted-but-wrong answers.
- Sits behind the sheet-scan front end and feeds the result/display logic.

Parameters:
- NUM_Q, 10: number of questions per sheet.
- NUM_OPT, 4: options per question; bits per question field.
- SCORE_W, 4: count width; must satisfy 2^SCORE_W > NUM_Q.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  high for one cycle when correct_answers and student_answers hold a sheet to grade.
- correct_answers  in  NUM_Q*NUM_OPT  answer key.
  - Question k occupies bits [k*NUM_OPT +: NUM_OPT].
  - Question 0 is the least significant field.
- student_answers  in  NUM_Q*NUM_OPT  student marks, same packing.
- score  out  SCORE_W  number of correctly answered questions.
- score1  out  SCORE_W  number of attempted-but-wrong questions.
- score_valid  out  1  one-cycle pulse; score and score1 hold a new result.

Behaviour:
- Per-question classification (combinational, field k):
  - key_ok: key field has exactly one bit set.
  - attempted: student field is non-zero.
  - correct: key_ok AND student field == key field. Bitwise equality with a one-hot key means exactly one mark.
  - wrong: attempted AND NOT correct. Covers a multi-mark field (e.g. 0101), a wrong single mark, and a mark against an invalid key.
  - blank (student field 0000): neither correct nor wrong, regardless of key.
- score_next = population count of correct over all NUM_Q questions.
- score1_next = population count of wrong over all NUM_Q questions.
- Sum rule: score + score1 <= NUM_Q always; counts never wrap.
- Latency: if in_valid is high at edge N, score, score1 and score_valid=1 are visible after edge N.
- score and score1 hold their values until the next accepted sheet.
- score_valid is high for exactly one cycle per accepted sheet.
- Back-to-back: in_valid high on consecutive cycles grades every sheet, one result per cycle. No stall and no backpressure.
- in_valid low: inputs ignored; outputs hold; score_valid=0.
- Reset (rst_n=0, asynchronous, any time including mid-stream):
  - score=0, score1=0, score_valid=0 immediately.
  - A sheet presented while rst_n=0 is discarded.
  - First sheet accepted is the first edge with rst_n=1 and in_valid=1.
- No X-propagation requirements beyond the reset values above.

Decomposition:
- Package omr_pkg: constants NUM_Q_DEF=10, NUM_OPT_DEF=4, SCORE_W_DEF=4.
- omr_pkg also holds a function returning the one-hot check of a NUM_OPT-bit field.
- Sub-module omr_question_grader, instantiated NUM_Q times via generate:
  - inputs: key field, student field.
  - outputs: correct, wrong.
- Top level: two popcount trees, output registers, valid register.

Test Plan:
- Key (q9..q0) = 0001_0010_0010_0100_0001_0010_0001_1000_1000_1000 for all scenarios below; one in_valid pulse each.
- Full match: student = key -> score=10, score1=0, score_valid pulses one cycle after in_valid.
- Partial: student = 1000_0010_0010_0100_0010_0100_0100_0100_1000_0010 -> score=4, score1=6.
- Multi-mark field: student = 1000_0100_0010_0001_0101_0010_0100_0010_0001_0010 -> score=2, score1=8 (q5=0101 counted wrong).
- All wrong then blanks:
  - student = 0100_0001_0100_1000_1000_0100_0100_0100_0001_0001 -> score=0, score1=10.
  - student = all zeros -> score=0, score1=0.
- Back-to-back and reset:
  - Send the full-match sheet, then student = 0001_0010_0010_0100_0001_0010_0001_0010_0001_1000 on consecutive cycles -> results 10 then 8 (score1=2) on consecutive cycles.
  - Assert rst_n=0 mid-cycle -> outputs 0 immediately; score_valid stays 0 until the next in_valid.
